// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection scheduler: light encodings, phase
// codes, the active-low 7-segment table and phase-to-light helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        NONE   = 2'b11
    } light_e;

    localparam logic [2:0] MAIN_GREEN  = 3'd0;
    localparam logic [2:0] MAIN_YELLOW = 3'd1;
    localparam logic [2:0] ALL_RED_A   = 3'd2;
    localparam logic [2:0] SIDE_GREEN  = 3'd3;
    localparam logic [2:0] SIDE_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_B   = 3'd5;

    // gfedcba, active low, index = hex digit
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic light_e main_light_of(input logic [2:0] phase);
        case (phase)
            MAIN_GREEN:  return GREEN;
            MAIN_YELLOW: return YELLOW;
            default:     return RED;
        endcase
    endfunction

    function automatic light_e side_light_of(input logic [2:0] phase);
        case (phase)
            SIDE_GREEN:  return GREEN;
            SIDE_YELLOW: return YELLOW;
            default:     return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the scheduler and its environment.
// Ped_Req/Walk exist only when TRAFFIC_PED_WALK_EN is defined.
interface traffic_phase_scheduler_if;

    logic       Tick_1Hz;
    logic       Side_Req;
    logic [1:0] Main_Light;
    logic [1:0] Side_Light;
    logic [2:0] Phase;
    logic [3:0] Time_Left;
    logic [6:0] Seg_Out;
`ifdef TRAFFIC_PED_WALK_EN
    logic       Ped_Req;
    logic       Walk;

    modport master (
        output Tick_1Hz, Side_Req, Ped_Req,
        input  Main_Light, Side_Light, Phase, Time_Left, Seg_Out, Walk
    );
    modport slave (
        input  Tick_1Hz, Side_Req, Ped_Req,
        output Main_Light, Side_Light, Phase, Time_Left, Seg_Out, Walk
    );
`else
    modport master (
        output Tick_1Hz, Side_Req,
        input  Main_Light, Side_Light, Phase, Time_Left, Seg_Out
    );
    modport slave (
        input  Tick_1Hz, Side_Req,
        output Main_Light, Side_Light, Phase, Time_Left, Seg_Out
    );
`endif

endinterface

// File: rtl/seg7_decoder.sv
// Hex digit to active-low 7-segment pattern (gfedcba).
module seg7_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_TABLE[digit_i];

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Main/side road phase scheduler advanced by a 1 Hz tick enable.
// Optional pedestrian request/walk signal: define TRAFFIC_PED_WALK_EN.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MAIN_T = 15,
    parameter int unsigned GREEN_SIDE_T = 10,
    parameter int unsigned YELLOW_T     = 5,
    parameter int unsigned ALLRED_T     = 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    traffic_phase_scheduler_if.slave  bus
);

    localparam logic [3:0] T_MG = 4'(GREEN_MAIN_T);
    localparam logic [3:0] T_SG = 4'(GREEN_SIDE_T);
    localparam logic [3:0] T_Y  = 4'(YELLOW_T);
    localparam logic [3:0] T_AR = 4'(ALLRED_T);

    logic [2:0] state_q, state_d;
    logic [3:0] time_q,  time_d;
    logic [1:0] main_q, side_q;
    logic       req_q,   req_d;
    logic       req_set;
    logic       expire;
    logic       enter_side;
    logic [6:0] seg;

`ifdef TRAFFIC_PED_WALK_EN
    logic walk_q;
    assign req_set = bus.Side_Req | bus.Ped_Req;
`else
    assign req_set = bus.Side_Req;
`endif

    assign expire = bus.Tick_1Hz && (time_q == 4'd1);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (bus.Tick_1Hz) begin
            time_d = time_q - 4'd1;
        end
        case (state_q)
            MAIN_GREEN: begin
                // Without a pending request the rest phase simply reloads.
                if (expire) begin
                    state_d = req_q ? MAIN_YELLOW : MAIN_GREEN;
                    time_d  = req_q ? T_Y : T_MG;
                end
            end
            MAIN_YELLOW: begin
                if (expire) begin
                    state_d = ALL_RED_A;
                    time_d  = T_AR;
                end
            end
            ALL_RED_A: begin
                if (expire) begin
                    state_d = SIDE_GREEN;
                    time_d  = T_SG;
                end
            end
            SIDE_GREEN: begin
                if (expire) begin
                    state_d = SIDE_YELLOW;
                    time_d  = T_Y;
                end
            end
            SIDE_YELLOW: begin
                if (expire) begin
                    state_d = ALL_RED_B;
                    time_d  = T_AR;
                end
            end
            ALL_RED_B: begin
                if (expire) begin
                    state_d = MAIN_GREEN;
                    time_d  = T_MG;
                end
            end
            default: begin
                state_d = MAIN_GREEN;
                time_d  = T_MG;
            end
        endcase
    end

    // Entering side green consumes the request, even one arriving that cycle.
    assign enter_side = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);
    assign req_d      = enter_side ? 1'b0 : (req_q | req_set);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= MAIN_GREEN;
            time_q  <= T_MG;
            main_q  <= GREEN;
            side_q  <= RED;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            main_q  <= main_light_of(state_d);
            side_q  <= side_light_of(state_d);
            req_q   <= req_d;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            walk_q <= 1'b0;
        end else begin
            walk_q <= (state_d == SIDE_GREEN);
        end
    end
    assign bus.Walk = walk_q;
`endif

    seg7_decoder u_seg7 (
        .digit_i (time_q),
        .seg_o   (seg)
    );

    assign bus.Main_Light = main_q;
    assign bus.Side_Light = side_q;
    assign bus.Phase      = state_q;
    assign bus.Time_Left  = time_q;
    assign bus.Seg_Out    = seg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: directed scenarios plus random ticks/requests/resets
// compared against a phase-table reference model.
module tb_traffic_phase_scheduler;

    localparam int GM = 15;
    localparam int GS = 10;
    localparam int YL = 5;
    localparam int AR = 1;

    logic Clock;
    logic Reset;
    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .GREEN_MAIN_T (GM),
        .GREEN_SIDE_T (GS),
        .YELLOW_T     (YL),
        .ALLRED_T     (AR)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Phase order 0..5 with durations and light colours (RED=0, YELLOW=1, GREEN=2)
    int DUR [6] = '{GM, YL, AR, GS, YL, AR};
    int ML  [6] = '{2, 1, 0, 0, 0, 0};
    int SL  [6] = '{0, 0, 0, 2, 1, 0};
    int SEG [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                     'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

    int mp;
    int mt;
    bit ml;
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clock(input bit tk, input bit set, input bit rs);
        bit entered;
        if (rs) begin
            mp = 0;
            mt = DUR[0];
            ml = 1'b0;
            return;
        end
        entered = 1'b0;
        if (tk) begin
            if (mt == 1) begin
                if (mp == 0 && !ml) begin
                    mt = DUR[0];
                end else begin
                    mp = (mp + 1) % 6;
                    mt = DUR[mp];
                    entered = (mp == 3);
                end
            end else begin
                mt = mt - 1;
            end
        end
        ml = entered ? 1'b0 : (ml | set);
    endtask

    task automatic compare_all();
        check("phase",     32'(bus.Phase),      32'(mp));
        check("main",      32'(bus.Main_Light), 32'(ML[mp]));
        check("side",      32'(bus.Side_Light), 32'(SL[mp]));
        check("time_left", 32'(bus.Time_Left),  32'(mt));
        check("seg",       32'(bus.Seg_Out),    32'(SEG[mt]));
`ifdef TRAFFIC_PED_WALK_EN
        check("walk",      32'(bus.Walk),       32'(mp == 3));
`endif
    endtask

    task automatic step(input bit tk, input bit rq, input bit rs, input bit pd);
        @(negedge Clock);
        bus.Tick_1Hz = tk;
        bus.Side_Req = rq;
        Reset        = rs;
`ifdef TRAFFIC_PED_WALK_EN
        bus.Ped_Req  = pd;
`endif
        @(posedge Clock);
        model_clock(tk, rq | pd, rs);
        #1;
        compare_all();
    endtask

    task automatic tick_until(input int p, input int t);
        int n;
        n = 0;
        while (!(mp == p && (t < 0 || mt == t)) && n < 200) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= 200) check("tick_until_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_phase(output int n);
        logic [2:0] ph;
        n  = 0;
        ph = bus.Phase;
        while (bus.Phase == ph && n < 100) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        bit tk, rq, rs, pd;

        bus.Tick_1Hz = 1'b0;
        bus.Side_Req = 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
        bus.Ped_Req  = 1'b0;
`endif
        Reset = 1'b1;
        mp = 0;
        mt = GM;
        ml = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_time",  32'(bus.Time_Left),  32'd15);
        check("rst_main",  32'(bus.Main_Light), 32'd2);
        check("rst_side",  32'(bus.Side_Light), 32'd0);
        check("rst_seg15", 32'(bus.Seg_Out),    32'h0E);

        // Rest in main green for 40 ticks
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("rest_phase", 32'(bus.Phase),     32'd0);
        check("rest_time",  32'(bus.Time_Left), 32'd5);

        // Request after tick 3: phase durations 12,5,1,10,5,1
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        count_phase(n); check("dur_main_green",  32'(n), 32'd12);
        count_phase(n); check("dur_main_yellow", 32'(n), 32'd5);
        count_phase(n); check("dur_all_red_a",   32'(n), 32'd1);
        count_phase(n); check("dur_side_green",  32'(n), 32'd10);
        count_phase(n); check("dur_side_yellow", 32'(n), 32'd5);
        count_phase(n); check("dur_all_red_b",   32'(n), 32'd1);
        check("back_phase", 32'(bus.Phase),     32'd0);
        check("back_time",  32'(bus.Time_Left), 32'd15);

        // Request on the very clock that enters side green is dropped
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_until(2, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("side_entry", 32'(bus.Phase), 32'd3);
        tick_until(0, -1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("no_second_side", 32'(bus.Phase), 32'd0);

        // Request during side yellow: one full main green, then side again
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_until(4, -1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_until(0, -1);
        count_phase(n);
        check("full_main_green", 32'(n), 32'd15);
        check("second_side",     32'(bus.Phase), 32'd1);

        // Reset mid side green with tick and request in the same cycle
        tick_until(0, -1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_until(3, 6);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("mid_rst_phase", 32'(bus.Phase),      32'd0);
        check("mid_rst_main",  32'(bus.Main_Light), 32'd2);
        check("mid_rst_side",  32'(bus.Side_Light), 32'd0);
        check("mid_rst_time",  32'(bus.Time_Left),  32'd15);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_rst_latch", 32'(bus.Phase), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tk = ($urandom_range(0, 1) == 1);
            rq = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 499) == 0);
`ifdef TRAFFIC_PED_WALK_EN
            pd = ($urandom_range(0, 59) == 0);
`else
            pd = 1'b0;
`endif
            step(tk, rq, rs, pd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
